video_raster_tracker: RTL and testbench
=======================================

VIDEO_RASTER_TRACKER -- requirements
Module: video_raster_tracker

Interface
REQ-001 Parameter H_ACTIVE, default 1920: active samples per line.
REQ-002 Parameter V_ACTIVE, default 1080: active lines per frame.
REQ-003 Parameter CELL_FINE, default 20: cell edge in pixels when gran_sel_i=0 (96x54 grid).
REQ-004 Parameter CELL_COARSE, default 120: cell edge in pixels when gran_sel_i=1 (16x9 grid).
REQ-005 Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- cen_i  in  1  clock enable; all state advances only when high.
- fvht_i  in  4  timing {F,V,H,T}; bit1 H=1 in horizontal blanking, bit2 V=1 in vertical blanking.
- gran_sel_i  in  1  cell-size select.
- fvht_o  out  4  fvht_i delayed one enabled cycle.
- active_o  out  1  current sample in active picture.
- sol_o  out  1  one-enabled-cycle pulse on first active sample of a line.
- sof_o  out  1  one-enabled-cycle pulse on first active sample of a frame.
- pos_x_o  out  12  active sample index 0..H_ACTIVE-1.
- pos_y_o  out  11  active line index 0..V_ACTIVE-1.
- cell_x_o  out  7  cell column.
- cell_y_o  out  6  cell row.
- chroma_sel_o  out  1  0=Cb sample, 1=Cr sample.
- locked_o  out  1  raster tracking valid.
- err_o  out  1  one-enabled-cycle pulse on line-length or frame-height violation.

Function
REQ-006 All outputs SHALL be registered, one enabled cycle after the fvht_i sample they describe; cen_i low SHALL hold every register.
REQ-007 H falling edge (prev 1, now 0) SHALL define line start; V falling edge SHALL define frame start; edges SHALL be detected against the previous enabled sample.
REQ-008 active_o SHALL equal (H==0 && V==0 && state==LOCKED).
REQ-009 pos_x_o SHALL be 0 on line start, increment by 1 each active sample, and saturate at H_ACTIVE-1.
REQ-010 pos_y_o SHALL be 0 on the first active line after frame start and increment at each subsequent line start while V==0.
REQ-011 chroma_sel_o SHALL be 0 on line start and toggle every active sample.
REQ-012 Cell coordinates SHALL be produced by sub-counters (no divider): cell_x_o increments when the x sub-counter reaches cell size-1, then sub-counter wraps to 0; same for cell_y_o per line.
REQ-013 gran_sel_i SHALL be sampled only at frame start; mid-frame changes SHALL take effect next frame.
REQ-014 FSM states: UNLOCKED, WAIT_FRAME, LOCKED.
REQ-015 UNLOCKED -> WAIT_FRAME on V rising edge; WAIT_FRAME -> LOCKED on V falling edge.
REQ-016 In LOCKED, H rising edge with active sample count != H_ACTIVE SHALL pulse err_o and go UNLOCKED.
REQ-017 In LOCKED, V rising edge with active line count != V_ACTIVE SHALL pulse err_o and go UNLOCKED.
REQ-018 sol_o and sof_o SHALL assert only in LOCKED; sof_o SHALL coincide with sol_o on line 0.
REQ-019 locked_o SHALL be 1 exactly when state==LOCKED.
REQ-020 Simultaneous H and V falling edges SHALL be treated as frame start plus line start on line 0.

Reset
REQ-021 With rst_n_i low at a clock edge (regardless of cen_i): state UNLOCKED; all outputs 0; edge history registers 1 (blanking).
REQ-022 Reset mid-line SHALL abandon the frame; relock requires a full V rising then falling edge.

Configuration
REQ-023 Macro VIDEO_RASTER_CELL_EN: defined -> cell counters and gran_sel_i sampling present per REQ-012/013; undefined -> cell logic removed, cell_x_o and cell_y_o tied 0, gran_sel_i ignored.

Verification
REQ-024 Reset, then 2 frames 1920x1080 with 280-sample H blank, 45-line V blank -> locked_o=1 from first V falling edge; sof_o once per frame; sol_o 1080 per frame; err_o never.
REQ-025 gran_sel_i=0 -> pixel (1919,1079) gives cell (95,53); pixel (20,19) gives cell (1,0).
REQ-026 gran_sel_i toggled to 1 mid-frame -> current frame unchanged; next frame pixel (1919,1079) gives cell (15,8).
REQ-027 One line with 1919 active samples -> err_o pulse at that H rising edge, locked_o=0, relock after next V rising+falling edge.
REQ-028 cen_i toggling 1-0 alternate cycles -> outputs identical to full-rate run per enabled sample; chroma_sel_o 0,1,0,1 from each line start.
REQ-029 rst_n_i low for 1 cycle at pos_x_o=500 -> all outputs 0 next cycle; active_o stays 0 until next frame start.

Source files
------------

// File: rtl/video_raster_tracker.sv
// Video raster tracker: follows an {F,V,H,T} timing stream, locks onto
// the frame structure and reports pixel/line/cell position per sample.
// Ports: clk_i, rst_n_i (sync, active-low), cen_i (clock enable),
//   fvht_i/gran_sel_i in; fvht_o, active_o, sol_o, sof_o, pos_x_o,
//   pos_y_o, cell_x_o, cell_y_o, chroma_sel_o, locked_o, err_o out.
// Optional macro VIDEO_RASTER_CELL_EN enables cell counters; otherwise
//   cell_x_o/cell_y_o are tied 0 and gran_sel_i is ignored.
module video_raster_tracker #(
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080,
    parameter int CELL_FINE   = 20,
    parameter int CELL_COARSE = 120
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cen_i,
    input  logic [3:0]  fvht_i,
    input  logic        gran_sel_i,
    output logic [3:0]  fvht_o,
    output logic        active_o,
    output logic        sol_o,
    output logic        sof_o,
    output logic [11:0] pos_x_o,
    output logic [10:0] pos_y_o,
    output logic [6:0]  cell_x_o,
    output logic [5:0]  cell_y_o,
    output logic        chroma_sel_o,
    output logic        locked_o,
    output logic        err_o
);

    localparam logic [11:0] HMAX  = 12'(H_ACTIVE - 1);
    localparam logic [10:0] VMAX  = 11'(V_ACTIVE - 1);
    localparam logic [11:0] H_LEN = 12'(H_ACTIVE);
    localparam logic [10:0] V_LEN = 11'(V_ACTIVE);

    typedef enum logic [1:0] {
        UNLOCKED,
        WAIT_FRAME,
        LOCKED
    } state_e;

    state_e      state_q, state_d;
    logic        h_prev_q, v_prev_q;
    logic        line_act_q, line_act_d;
    logic        first_q, first_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d, vbase;
    logic [3:0]  fvht_q;
    logic        active_q, active_d;
    logic        sol_q, sol_d;
    logic        sof_q, sof_d;
    logic [11:0] pos_x_q, pos_x_d;
    logic [10:0] pos_y_q, pos_y_d;
    logic        chroma_q, chroma_d;
    logic        locked_q;
    logic        err_q, err_d;

    logic h, v, h_fall, h_rise, v_fall, v_rise;
    logic lock_n, act, line_start, new_frame;

    assign h      = fvht_i[1];
    assign v      = fvht_i[2];
    assign h_fall = h_prev_q & ~h;
    assign h_rise = ~h_prev_q & h;
    assign v_fall = v_prev_q & ~v;
    assign v_rise = ~v_prev_q & v;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            UNLOCKED:   if (v_rise) state_d = WAIT_FRAME;
            WAIT_FRAME: if (v_fall) state_d = LOCKED;
            LOCKED: begin
                // line_act_q limits the length check to lines whose
                // start was seen while locked
                if ((h_rise && line_act_q && hcnt_q != H_LEN) ||
                    (v_rise && vcnt_q != V_LEN)) begin
                    err_d   = 1'b1;
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // Gating on the post-edge state lets the locking sample be active.
    assign lock_n     = (state_d == LOCKED);
    assign act        = ~h & ~v & lock_n;
    assign line_start = h_fall & ~v & lock_n;
    assign new_frame  = first_q | v_fall;

    always_comb begin
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        chroma_d   = chroma_q;
        hcnt_d     = hcnt_q;
        line_act_d = line_act_q;
        first_d    = first_q;
        vbase      = v_fall ? 11'd0 : vcnt_q;
        vcnt_d     = vbase;
        active_d   = act;
        sol_d      = line_start;
        sof_d      = line_start & new_frame;
        if (line_start) begin
            pos_x_d    = '0;
            chroma_d   = 1'b0;
            hcnt_d     = 12'd1;
            line_act_d = 1'b1;
            first_d    = 1'b0;
            if (new_frame) pos_y_d = '0;
            else if (pos_y_q != VMAX) pos_y_d = pos_y_q + 11'd1;
            if (vbase != '1) vcnt_d = vbase + 11'd1;
        end else begin
            if (v_fall) first_d = 1'b1;
            if (h_rise) line_act_d = 1'b0;
            if (act) begin
                chroma_d = ~chroma_q;
                if (pos_x_q != HMAX) pos_x_d = pos_x_q + 12'd1;
                if (hcnt_q != '1) hcnt_d = hcnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= UNLOCKED;
            h_prev_q   <= 1'b1;
            v_prev_q   <= 1'b1;
            line_act_q <= 1'b0;
            first_q    <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            fvht_q     <= '0;
            active_q   <= 1'b0;
            sol_q      <= 1'b0;
            sof_q      <= 1'b0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            chroma_q   <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else if (cen_i) begin
            state_q    <= state_d;
            h_prev_q   <= h;
            v_prev_q   <= v;
            line_act_q <= line_act_d;
            first_q    <= first_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            fvht_q     <= fvht_i;
            active_q   <= active_d;
            sol_q      <= sol_d;
            sof_q      <= sof_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            chroma_q   <= chroma_d;
            locked_q   <= lock_n;
            err_q      <= err_d;
        end
    end

    assign fvht_o       = fvht_q;
    assign active_o     = active_q;
    assign sol_o        = sol_q;
    assign sof_o        = sof_q;
    assign pos_x_o      = pos_x_q;
    assign pos_y_o      = pos_y_q;
    assign chroma_sel_o = chroma_q;
    assign locked_o     = locked_q;
    assign err_o        = err_q;

`ifdef VIDEO_RASTER_CELL_EN
    localparam int CMAX = (CELL_FINE > CELL_COARSE) ? CELL_FINE : CELL_COARSE;
    localparam int SW   = $clog2(CMAX + 1);

    logic          gran_q, gran_d;
    logic [SW-1:0] sx_q, sx_d, sy_q, sy_d, csz_m1;
    logic [6:0]    cx_q, cx_d;
    logic [5:0]    cy_q, cy_d;

    always_comb begin
        // granularity follows the input only on the frame-start sample
        gran_d = v_fall ? gran_sel_i : gran_q;
        csz_m1 = gran_d ? SW'(CELL_COARSE - 1) : SW'(CELL_FINE - 1);
        sx_d   = sx_q;
        cx_d   = cx_q;
        sy_d   = sy_q;
        cy_d   = cy_q;
        if (line_start) begin
            sx_d = '0;
            cx_d = '0;
            if (new_frame) begin
                sy_d = '0;
                cy_d = '0;
            end else if (pos_y_q != VMAX) begin
                if (sy_q == csz_m1) begin
                    sy_d = '0;
                    cy_d = cy_q + 6'd1;
                end else begin
                    sy_d = sy_q + 1'b1;
                end
            end
        end else if (act && pos_x_q != HMAX) begin
            if (sx_q == csz_m1) begin
                sx_d = '0;
                cx_d = cx_q + 7'd1;
            end else begin
                sx_d = sx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gran_q <= 1'b0;
            sx_q   <= '0;
            sy_q   <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
        end else if (cen_i) begin
            gran_q <= gran_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
        end
    end

    assign cell_x_o = cx_q;
    assign cell_y_o = cy_q;
`else
    logic unused_gran;
    assign unused_gran = gran_sel_i;
    assign cell_x_o    = '0;
    assign cell_y_o    = '0;
`endif

endmodule

// File: tb/tb_video_raster_tracker.sv
// Bench for video_raster_tracker on a scaled-down 40x20 raster.
// Table of pixel checkpoints plus per-frame pulse/activity counts.
module tb_video_raster_tracker;

    localparam int HA = 40;
    localparam int VA = 20;
    localparam int HB = 8;
    localparam int VB = 3;
    localparam int CF = 4;
    localparam int CC = 10;
    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst_n_i, cen_i, gran_sel_i;
    logic [3:0]  fvht_i, fvht_o;
    logic        active_o, sol_o, sof_o, chroma_sel_o, locked_o, err_o;
    logic [11:0] pos_x_o;
    logic [10:0] pos_y_o;
    logic [6:0]  cell_x_o;
    logic [5:0]  cell_y_o;

    always #5 clk = ~clk;

    video_raster_tracker #(
        .H_ACTIVE(HA), .V_ACTIVE(VA),
        .CELL_FINE(CF), .CELL_COARSE(CC)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .cen_i(cen_i),
        .fvht_i(fvht_i), .gran_sel_i(gran_sel_i),
        .fvht_o(fvht_o), .active_o(active_o),
        .sol_o(sol_o), .sof_o(sof_o),
        .pos_x_o(pos_x_o), .pos_y_o(pos_y_o),
        .cell_x_o(cell_x_o), .cell_y_o(cell_y_o),
        .chroma_sel_o(chroma_sel_o), .locked_o(locked_o),
        .err_o(err_o)
    );

    // frame, line, pixel, then expected act,sol,sof,lock,chroma,x,y,cx,cy
    typedef struct {
        int fr; int ln; int px;
        int act; int sol; int sof; int lk; int ch;
        int x; int y; int cx; int cy;
    } vec_t;

    vec_t       tbl[NV];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cur_f, cur_l, cur_p;
    int         n_sof, n_sol, n_err, n_act;
    logic [3:0] last_fv;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({active_o, sol_o, sof_o, locked_o, err_o, chroma_sel_o,
                    pos_x_o, pos_y_o, cell_x_o, cell_y_o, fvht_o});
    endfunction

    function automatic logic [63:0] exp_of(input vec_t e);
        logic [6:0] cx;
        logic [5:0] cy;
`ifdef VIDEO_RASTER_CELL_EN
        cx = 7'(e.cx);
        cy = 6'(e.cy);
`else
        cx = 7'd0;
        cy = 6'd0;
`endif
        return 64'({1'(e.act), 1'(e.sol), 1'(e.sof), 1'(e.lk), 1'b0,
                    1'(e.ch), 12'(e.x), 11'(e.y), cx, cy, last_fv});
    endfunction

    task automatic eval_out(input bit held);
        if (!held) begin
            n_sof += int'(sof_o);
            n_sol += int'(sol_o);
            n_err += int'(err_o);
            n_act += int'(active_o);
            if (err_o) chk("err_unlock", 64'({locked_o, active_o}), 64'd0);
        end
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].fr == cur_f && tbl[i].ln == cur_l &&
                tbl[i].px == cur_p)
                chk($sformatf("%s%0d", held ? "hold" : "vec", i),
                    outs(), exp_of(tbl[i]));
        end
    endtask

    task automatic step(input logic [3:0] f, input bit gap);
        fvht_i  = f;
        cen_i   = 1'b1;
        last_fv = f;
        @(posedge clk);
        #1;
        eval_out(1'b0);
        if (gap) begin
            cen_i  = 1'b0;
            fvht_i = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            eval_out(1'b1);
        end
    endtask

    task automatic rst_pulse();
        rst_n_i = 1'b0;
        cen_i   = 1'b0;
        fvht_i  = 4'b0000;
        @(posedge clk);
        #1;
        chk("rst_mid", outs(), 64'd0);
        rst_n_i = 1'b1;
    endtask

    task automatic run_frame(input int fr, input bit gap, input int tog,
                             input int short_ln, input int rl, input int rp);
        int len;
        cur_f = fr;
        n_sof = 0;
        n_sol = 0;
        n_err = 0;
        n_act = 0;
        cur_l = -1;
        cur_p = -1;
        for (int l = 0; l < VB; l++) begin
            for (int s = 0; s < HB; s++) step(4'b0111, gap);
            for (int s = 0; s < HA; s++) step(4'b0100, gap);
        end
        for (int i = 0; i < VA; i++) begin
            cur_l = i;
            cur_p = -1;
            if (i == tog) gran_sel_i = ~gran_sel_i;
            for (int s = 0; s < HB; s++)
                step({1'b0, logic'(i == 0), 2'b11}, gap);
            len = (i == short_ln) ? HA - 1 : HA;
            for (int p = 0; p < len; p++) begin
                if (i == rl && p == rp) begin
                    rst_pulse();
                end else begin
                    cur_p = p;
                    step(4'b0000, gap);
                end
            end
        end
    endtask

    task automatic frame_stats(input int fr, input int e_sof,
                               input int e_sol, input int e_err,
                               input int e_act);
        chk($sformatf("f%0d_sof", fr), 64'(n_sof), 64'(e_sof));
        chk($sformatf("f%0d_sol", fr), 64'(n_sol), 64'(e_sol));
        chk($sformatf("f%0d_err", fr), 64'(n_err), 64'(e_err));
        chk($sformatf("f%0d_act", fr), 64'(n_act), 64'(e_act));
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 3, 4, 1, 0, 0, 1, 0, 4, 3, 1, 0};
        tbl[4]  = '{0, 4, 3, 1, 0, 0, 1, 1, 3, 4, 0, 1};
        tbl[5]  = '{0, 19, 39, 1, 0, 0, 1, 1, 39, 19, 9, 4};
        tbl[6]  = '{1, 12, 39, 1, 0, 0, 1, 1, 39, 12, 9, 3};
        tbl[7]  = '{1, 19, 39, 1, 0, 0, 1, 1, 39, 19, 9, 4};
        tbl[8]  = '{2, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{2, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        tbl[10] = '{2, 0, 2, 1, 0, 0, 1, 0, 2, 0, 0, 0};
        tbl[11] = '{2, 0, 3, 1, 0, 0, 1, 1, 3, 0, 0, 0};
        tbl[12] = '{2, 10, 10, 1, 0, 0, 1, 0, 10, 10, 1, 1};
        tbl[13] = '{2, 19, 39, 1, 0, 0, 1, 1, 39, 19, 3, 1};
        tbl[14] = '{4, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[15] = '{4, 2, 7, 1, 0, 0, 1, 1, 7, 2, 1, 0};
        tbl[16] = '{5, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[17] = '{5, 19, 39, 1, 0, 0, 1, 1, 39, 19, 9, 4};

        cur_f      = -1;
        cur_l      = -1;
        cur_p      = -1;
        last_fv    = 4'b0000;
        rst_n_i    = 1'b0;
        cen_i      = 1'b0;
        fvht_i     = 4'b0000;
        gran_sel_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", outs(), 64'd0);
        rst_n_i = 1'b1;

        // partial active region so the first frame sees a V rising edge
        for (int s = 0; s < 20; s++) step(4'b0000, 1'b0);
        chk("prelock", 64'(locked_o), 64'd0);

        run_frame(0, 1'b0, -1, -1, -1, -1);
        frame_stats(0, 1, VA, 0, HA * VA);

        run_frame(1, 1'b0, 10, -1, -1, -1);
        frame_stats(1, 1, VA, 0, HA * VA);

        run_frame(2, 1'b1, -1, -1, -1, -1);
        frame_stats(2, 1, VA, 0, HA * VA);

        gran_sel_i = 1'b0;
        run_frame(3, 1'b0, -1, 5, -1, -1);
        frame_stats(3, 1, 6, 1, 5 * HA + HA - 1);
        chk("f3_unlocked", 64'(locked_o), 64'd0);

        run_frame(4, 1'b0, -1, -1, 3, 25);
        frame_stats(4, 1, 4, 0, 3 * HA + 25);
        chk("f4_unlocked", 64'({locked_o, active_o}), 64'd0);

        run_frame(5, 1'b0, -1, -1, -1, -1);
        frame_stats(5, 1, VA, 0, HA * VA);

        // V rising edge after a full frame must not flag an error
        cur_f = 6;
        cur_l = -1;
        cur_p = -1;
        n_err = 0;
        for (int s = 0; s < HB; s++) step(4'b0111, 1'b0);
        chk("tail_err", 64'(n_err), 64'd0);
        chk("tail_lock", 64'(locked_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
